// File: rtl/as1_eval_arbiter.sv
// Round-robin arbiter sharing one combinational evaluation unit between two requesters.
// Drives func_in, waits SETTLE cycles, samples func_out, then holds the result until the owner takes it.
module as1_eval_arbiter #(
  parameter int unsigned W      = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_code,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic         rsp0_data,
  input  logic         rsp0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_code,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic         rsp1_data,
  input  logic         rsp1_ready,
  output logic [W-1:0] func_in,
  input  logic         func_out,
  output logic         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       owner;
  logic       grant_valid;
  logic       grant;

  // Ready is held low while reset is asserted so nothing looks accepted during reset.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state == IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant       = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid & ~grant;
  assign req1_ready = grant_valid &  grant;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      func_in    <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            func_in    <= grant ? req1_code : req0_code;
            cnt        <= SETTLE_C;
            last_grant <= grant;
            owner      <= grant;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (owner) begin
              rsp1_data  <= func_out;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_data  <= func_out;
              rsp0_valid <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_as1_eval_arbiter.sv
// Directed bench for as1_eval_arbiter: three instances with SETTLE = 1, 4, 3,
// each fed by a parity evaluation stub.
module tb_as1_eval_arbiter;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic       req0_valid [3];
  logic [3:0] req0_code  [3];
  logic       req0_ready [3];
  logic       rsp0_valid [3];
  logic       rsp0_data  [3];
  logic       rsp0_ready [3];
  logic       req1_valid [3];
  logic [3:0] req1_code  [3];
  logic       req1_ready [3];
  logic       rsp1_valid [3];
  logic       rsp1_data  [3];
  logic       rsp1_ready [3];
  logic [3:0] func_in    [3];
  logic       func_out   [3];
  logic       busy       [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    as1_eval_arbiter #(.W(4), .SETTLE(k == 0 ? 1 : (k == 1 ? 4 : 3))) dut (
      .clk(clk), .rst_n(rst_n[k]),
      .req0_valid(req0_valid[k]), .req0_code(req0_code[k]), .req0_ready(req0_ready[k]),
      .rsp0_valid(rsp0_valid[k]), .rsp0_data(rsp0_data[k]), .rsp0_ready(rsp0_ready[k]),
      .req1_valid(req1_valid[k]), .req1_code(req1_code[k]), .req1_ready(req1_ready[k]),
      .rsp1_valid(rsp1_valid[k]), .rsp1_data(rsp1_data[k]), .rsp1_ready(rsp1_ready[k]),
      .func_in(func_in[k]), .func_out(func_out[k]), .busy(busy[k])
    );
    assign func_out[k] = ^func_in[k];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until one requester of instance k is granted; g = -1 on timeout.
  task automatic wait_ready(input int k, output int g);
    g = -1;
    #1;
    for (int n = 0; n < 30; n++) begin
      if (req0_ready[k]) begin g = 0; break; end
      if (req1_ready[k]) begin g = 1; break; end
      step();
      #1;
    end
  endtask

  task automatic wait_rsp(input int k, input int r, output int d);
    d = -1;
    for (int n = 0; n < 30; n++) begin
      if (r == 0 && rsp0_valid[k]) begin d = int'(rsp0_data[k]); break; end
      if (r == 1 && rsp1_valid[k]) begin d = int'(rsp1_data[k]); break; end
      step();
    end
  endtask

  task automatic outs_reset(input int k, input string tag);
    check({tag, "_busy"},   32'(busy[k]),       0);
    check({tag, "_func"},   32'(func_in[k]),    0);
    check({tag, "_rv0"},    32'(rsp0_valid[k]), 0);
    check({tag, "_rv1"},    32'(rsp1_valid[k]), 0);
    check({tag, "_rd0"},    32'(rsp0_data[k]),  0);
    check({tag, "_rd1"},    32'(rsp1_data[k]),  0);
    check({tag, "_rdy0"},   32'(req0_ready[k]), 0);
    check({tag, "_rdy1"},   32'(req1_ready[k]), 0);
  endtask

  initial begin
    int g, d, acc, prev;
    logic [3:0] code;

    // 1: reset with random inputs
    rst_n = '0;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 3; k++) begin
        req0_valid[k] = 1'($urandom); req0_code[k] = 4'($urandom);
        req1_valid[k] = 1'($urandom); req1_code[k] = 4'($urandom);
        rsp0_ready[k] = 1'($urandom); rsp1_ready[k] = 1'($urandom);
      end
      step();
      for (int k = 0; k < 3; k++) outs_reset(k, "rst");
    end
    for (int k = 0; k < 3; k++) begin
      req0_valid[k] = 0; req1_valid[k] = 0; req0_code[k] = 0; req1_code[k] = 0;
      rsp0_ready[k] = 1; rsp1_ready[k] = 1;
    end
    rst_n = '1;
    step();

    // 2: SETTLE=1 single transaction on instance 0
    req0_valid[0] = 1; req0_code[0] = 4'b0111; rsp0_ready[0] = 0;
    #1;
    check("t2_ready", 32'(req0_ready[0]), 1);
    step();
    req0_valid[0] = 0;
    check("t2_func", 32'(func_in[0]), 32'b0111);
    check("t2_busy", 32'(busy[0]), 1);
    check("t2_rv_early", 32'(rsp0_valid[0]), 0);
    step();
    check("t2_rv", 32'(rsp0_valid[0]), 1);
    check("t2_rd", 32'(rsp0_data[0]), 1);
    rsp0_ready[0] = 1;
    step();
    check("t2_rv_done", 32'(rsp0_valid[0]), 0);
    check("t2_idle", 32'(busy[0]), 0);

    // 3: both valid on instance 2 from reset -> grants alternate 0,1,0,1
    req0_valid[2] = 1; req0_code[2] = 4'b0011;
    req1_valid[2] = 1; req1_code[2] = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      wait_ready(2, g);
      check("t3_grant", 32'(g), 32'(t % 2));
      step();
      wait_rsp(2, t % 2, d);
      check("t3_data", 32'(d), (t % 2 == 0) ? 0 : 1);
    end
    req0_valid[2] = 0;
    prev = 0;
    for (int t = 0; t < 3; t++) begin
      wait_ready(2, g);
      check("t3_solo_grant", 32'(g), 1);
      step();
      acc = cyc;
      if (t > 0) check("t3_solo_gap", 32'(acc - prev), 5);
      prev = acc;
      wait_rsp(2, 1, d);
      check("t3_solo_data", 32'(d), 1);
    end
    req1_valid[2] = 0;
    step(); step();

    // 4: rsp1_ready held low with req0 pending on instance 0
    rsp1_ready[0] = 0;
    req1_valid[0] = 1; req1_code[0] = 4'b1011;
    wait_ready(0, g);
    check("t4_grant1", 32'(g), 1);
    step();
    req1_valid[0] = 0;
    req0_valid[0] = 1; req0_code[0] = 4'b0110;
    step();
    for (int n = 0; n < 5; n++) begin
      check("t4_rv1", 32'(rsp1_valid[0]), 1);
      check("t4_rd1", 32'(rsp1_data[0]), 1);
      check("t4_rdy0", 32'(req0_ready[0]), 0);
      check("t4_busy", 32'(busy[0]), 1);
      check("t4_rv0", 32'(rsp0_valid[0]), 0);
      step();
    end
    rsp1_ready[0] = 1;
    #1;
    check("t4_rdy0_resp", 32'(req0_ready[0]), 0);
    step();
    rsp1_ready[0] = 0;
    #1;
    check("t4_rv1_drop", 32'(rsp1_valid[0]), 0);
    check("t4_rdy0_idle", 32'(req0_ready[0]), 1);
    step();
    req0_valid[0] = 0;
    check("t4_func", 32'(func_in[0]), 32'b0110);
    wait_rsp(0, 0, d);
    check("t4_rd0", 32'(d), 0);
    step();

    // 5: reset pulse mid-DRIVE on instance 1 (SETTLE=4, cnt=2)
    req0_valid[1] = 1; req0_code[1] = 4'b1110;
    wait_ready(1, g);
    check("t5_grant", 32'(g), 0);
    step();
    req0_valid[1] = 0;
    step(); step();
    rst_n[1] = 0;
    #2;
    outs_reset(1, "t5_rst");
    rst_n[1] = 1;
    for (int n = 0; n < 6; n++) begin
      step();
      check("t5_no_rsp", 32'(rsp0_valid[1]), 0);
    end
    req1_valid[1] = 1; req1_code[1] = 4'b0101;
    wait_ready(1, g);
    check("t5_next_grant", 32'(g), 1);
    step();
    req1_valid[1] = 0;
    check("t5_func", 32'(func_in[1]), 32'b0101);
    wait_rsp(1, 1, d);
    check("t5_next_data", 32'(d), 0);

    // 6: SETTLE=3 parity sweep on instance 2
    prev = 0;
    req0_valid[2] = 1;
    for (int i = 0; i < 16; i++) begin
      code = 4'(i);
      req0_code[2] = code;
      wait_ready(2, g);
      check("t6_grant", 32'(g), 0);
      step();
      acc = cyc;
      if (i > 0) check("t6_gap", 32'(acc - prev), 5);
      prev = acc;
      wait_rsp(2, 0, d);
      check("t6_data", 32'(d), 32'(code[0] ^ code[1] ^ code[2] ^ code[3]));
    end
    req0_valid[2] = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
